adder_tree_ctrl: RTL and testbench
==================================

# adder_tree_ctrl

Sequencing controller for the pooling/nonlinear adder tree. It accepts a reduction job (active PE count, number of passes) and admits one MAC result vector per pass through a valid/ready handshake. It drives the tree's `adder_enable` and per-PE `mac_enable` mask, tracks beats through the 5-stage tree pipeline, and accumulates the tree outputs across passes. It presents one reduced result per job on a valid/ready output port. It sits between the PE array result bus and the pool/NL output stage, alongside `adder_tree`.

## Interface
- `N_PE`, default `` `N_PE `` (32): tree input count; must be 32 (fixed 5-stage tree).
- `WID`, default `` `WID_PE_BITS ``: tree and result width, signed.
- `PASS_W`, default 8: width of the pass counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `job_start` in 1: single-cycle pulse that starts a job; accepted only in IDLE.
- `job_n_pe` in `$clog2(N_PE)+1`: number of active PEs, lowest indices; 0 is treated as `N_PE`.
- `job_n_pass` in `PASS_W`: number of MAC vectors to reduce; 0 is treated as 1.
- `in_valid` in 1: the PE array has a result vector on the tree's MAC input this cycle.
- `in_ready` out 1: the controller accepts that vector this cycle.
- `adder_enable` out 1: tree pipeline advance.
- `mac_enable` out `N_PE`: per-PE clean mask to the tree.
- `adder_tree_out` in `WID` signed: tree result.
- `out_valid` out 1, `out_ready` in 1, `out_data` out `WID` signed: result handshake.
- `busy` out 1: high in any state except IDLE.

## Operation
- States:
  - IDLE: `job_start` latches `pe_mask_q` (low `job_n_pe` bits set), `n_pass_q`, clears counters and accumulator, then moves to FEED.
  - FEED: `in_ready = 1` while `accepted < n_pass_q`. When the last beat is accepted, move to DRAIN.
  - DRAIN: `in_ready = 0`. Move to OUT on the edge that retires the final tagged beat.
  - OUT: `out_valid = 1`; hold `out_data` stable until `out_ready`, then return to IDLE.
- `adder_enable = 1` in FEED and DRAIN, 0 in IDLE and OUT. The tree never stalls mid-job.
- `mac_enable = pe_mask_q` when `in_valid && in_ready`, otherwise all-zero. This is combinational, in the same cycle as the beat. Non-accepted cycles inject zeros.
- A 5-bit tag shift register mirrors the tree stages:
  - bit 0 is loaded with `in_valid && in_ready`;
  - it shifts only when `adder_enable` is high;
  - bit 4 qualifies `adder_tree_out`.
- When bit 4 is set, the accumulator adds `adder_tree_out` and `retired` increments.
- Accumulator is `WID+PASS_W` bits signed, sign-extended adds. `out_data` is the accumulator narrowed to `WID` (per Configuration).
- `job_start` outside IDLE is ignored, with no side effects.
- Simultaneous `in_valid` and the last-beat acceptance: the beat is accepted and the state moves to DRAIN on the same edge.
- Reset at any time: state returns to IDLE and counters, tags and accumulator clear. Any in-flight tree data is abandoned.

## Timing
- Reset values: `in_ready` 0, `adder_enable` 0, `mac_enable` 0, `out_valid` 0, `out_data` 0, `busy` 0.
- `job_start` in cycle 0 puts the block in FEED from cycle 1; the earliest acceptance is cycle 1.
- A beat accepted in cycle t appears on `adder_tree_out` in cycle t+5 and is accumulated on that edge.
- If the last beat is accepted in cycle L, `out_valid` is asserted from cycle L+6.
- With `in_valid` held high, `out_valid` therefore rises in cycle `n_pass+6` after `job_start`.
- `out_valid` drops the cycle after the `out_valid && out_ready` handshake. A new `job_start` is legal in that next cycle.
- `busy` is registered and follows the state.

## Configuration
- `ACC_SAT_EN` defined: the accumulator saturates at the `WID+PASS_W` bounds, and `out_data` saturates to the signed `WID` range (max `2^(WID-1)-1`, min `-2^(WID-1)`).
- `ACC_SAT_EN` undefined: the accumulator wraps, and `out_data` is the low `WID` bits (two's-complement wrap).

## Structure
- Package `pool_nl_pkg` holds:
  - the state enum `adder_ctrl_state_t` (IDLE, FEED, DRAIN, OUT);
  - `localparam ADDER_TREE_LAT = 5`;
  - the function `pe_mask(n)` that builds the low-n-bits mask.
- One sub-module, `tag_pipe`: a parameterized enable-gated valid shift register of depth `ADDER_TREE_LAT`.
- The accumulator and narrowing logic stay in the top module.

## Test plan
- n_pe=32, n_pass=1, all PEs = 1, `in_valid` high: one `mac_enable` = 0xFFFFFFFF beat in cycle 1 → `out_data` = 32 in cycle 7.
- n_pe=4, n_pass=3, PE value = 2 (all 32 driven): masks are 0x0000000F → `out_data` = 24. The `in_valid` gap between beats 1 and 2 delays `out_valid` by one cycle.
- n_pass=0, n_pe=0, all PEs = −1: treated as 1 pass × 32 PEs → `out_data` = −32.
- `out_ready` held low 10 cycles with `out_data` = 5: `out_valid` and `out_data` stay stable. A `job_start` pulse during the hold is ignored, and `busy` stays 1.
- `ACC_SAT_EN`, WID=16, n_pass=4, tree sum = 16000 per pass:
  - with the macro: `out_data` = 32767;
  - without the macro: `out_data` = 64000 mod 2^16 → −1536.
- `rst` low in DRAIN, with 2 beats in flight: all outputs go to 0 within the reset cycle. A new job after release yields the correct sum, with no stale contribution.

Source files
------------

// File: rtl/pool_nl_pkg.sv
// Shared types and helpers for the pooling/nonlinear adder tree controller.
package pool_nl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } adder_ctrl_state_t;

  // Register stages between the tree's MAC input and adder_tree_out.
  localparam int ADDER_TREE_LAT = 5;

  // The tree is built for exactly this many inputs.
  localparam int TREE_N_PE = 32;

  // Mask with the low n bits set. A count of 0 selects every PE.
  function automatic logic [TREE_N_PE-1:0] pe_mask(input logic [$clog2(TREE_N_PE):0] n);
    logic [TREE_N_PE-1:0] m;
    int                   n_eff;
    n_eff = (n == '0) ? TREE_N_PE : int'(n);
    for (int i = 0; i < TREE_N_PE; i++) begin
      m[i] = (i < n_eff);
    end
    return m;
  endfunction

endpackage

// File: rtl/adder_tree_ctrl_tag_pipe.sv
// Enable-gated valid shift register that tracks which tree stages hold a real beat.
module tag_pipe #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic tag_last
);

  logic [DEPTH-1:0] tags;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Each stage advances together with the tree pipeline.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tags[gi] <= 1'b0;
        end else if (en) begin
          if (gi == 0) begin
            tags[gi] <= din;
          end else begin
            tags[gi] <= tags[(gi == 0) ? 0 : gi-1];
          end
        end
      end
    end
  endgenerate

  assign tag_last = tags[DEPTH-1];

endmodule

// File: rtl/adder_tree_ctrl.sv
// Sequencing controller for the pool/NL adder tree: admits one MAC vector per
// pass, tracks beats through the tree, accumulates tree outputs, and returns one
// reduced result per job. Optional macro ACC_SAT_EN selects saturating
// accumulation and output narrowing; otherwise both wrap.
`ifndef N_PE
`define N_PE 32
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

module adder_tree_ctrl
  import pool_nl_pkg::*;
#(
  parameter int N_PE   = `N_PE,
  parameter int WID    = `WID_PE_BITS,
  parameter int PASS_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_start,
  input  logic [$clog2(N_PE):0]     job_n_pe,
  input  logic [PASS_W-1:0]         job_n_pass,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      adder_enable,
  output logic [N_PE-1:0]           mac_enable,
  input  logic signed [WID-1:0]     adder_tree_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WID-1:0]     out_data,
  output logic                      busy
);

  localparam int ACC_W = WID + PASS_W;

  adder_ctrl_state_t        state, state_next;
  logic [N_PE-1:0]          pe_mask_q;
  logic [PASS_W-1:0]        n_pass_q;
  logic [PASS_W-1:0]        accepted;
  logic [PASS_W-1:0]        retired;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [WID-1:0]    acc_narrow;
  logic                     accept;
  logic                     tag_out;
  logic                     last_retire;

  assign accept      = in_valid && in_ready;
  assign last_retire = tag_out && (retired == n_pass_q - 1'b1);
  assign mac_enable  = accept ? pe_mask_q : '0;

  tag_pipe #(
    .DEPTH (ADDER_TREE_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (adder_enable),
    .din      (accept),
    .tag_last (tag_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    adder_enable = 1'b0;
    out_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (job_start) state_next = FEED;
      end
      FEED: begin
        adder_enable = 1'b1;
        in_ready     = (accepted < n_pass_q);
        if (in_valid && in_ready && (accepted == n_pass_q - 1'b1)) state_next = DRAIN;
      end
      DRAIN: begin
        adder_enable = 1'b1;
        if (last_retire) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [WID-1:0]   OUT_MAX = {1'b0, {(WID-1){1'b1}}};
  localparam logic signed [WID-1:0]   OUT_MIN = {1'b1, {(WID-1){1'b0}}};

  logic signed [ACC_W:0]   sum_wide;
  logic [ACC_W-WID:0]      acc_hi;

  // One extra bit exposes overflow; clamp to the accumulator bounds.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {{(PASS_W+1){adder_tree_out[WID-1]}}, adder_tree_out};
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum_wide[ACC_W-1:0];
    end
  end

  // Narrow to WID, clamping when the upper bits are not pure sign extension.
  always_comb begin
    acc_hi = acc[ACC_W-1:WID-1];
    if ((&acc_hi) || !(|acc_hi)) begin
      acc_narrow = acc[WID-1:0];
    end else begin
      acc_narrow = acc[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end
`else
  // Wrapping accumulate and plain truncation.
  always_comb begin
    acc_next   = acc + {{PASS_W{adder_tree_out[WID-1]}}, adder_tree_out};
    acc_narrow = acc[WID-1:0];
  end
`endif

  assign out_data = out_valid ? acc_narrow : '0;

  // Job registers, beat counters and accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_mask_q <= '0;
      n_pass_q  <= '0;
      accepted  <= '0;
      retired   <= '0;
      acc       <= '0;
    end else if (state == IDLE) begin
      if (job_start) begin
        pe_mask_q <= pe_mask(job_n_pe);
        n_pass_q  <= (job_n_pass == '0) ? PASS_W'(1) : job_n_pass;
        accepted  <= '0;
        retired   <= '0;
        acc       <= '0;
      end
    end else begin
      if (accept) accepted <= accepted + 1'b1;
      if (tag_out) begin
        retired <= retired + 1'b1;
        acc     <= acc_next;
      end
    end
  end

  // Registered busy flag tracking the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// Scoreboard bench for adder_tree_ctrl with a behavioural 5-stage tree model.
// Expected sums depend on ACC_SAT_EN in the saturation case.
module tb_adder_tree_ctrl;

  localparam int N_PE   = 32;
  localparam int WID    = 16;
  localparam int PASS_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  job_start;
  logic [5:0]            job_n_pe;
  logic [PASS_W-1:0]     job_n_pass;
  logic                  in_valid;
  logic                  in_ready;
  logic                  adder_enable;
  logic [N_PE-1:0]       mac_enable;
  logic signed [WID-1:0] adder_tree_out;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [WID-1:0] out_data;
  logic                  busy;

  int checks   = 0;
  int failures = 0;
  logic signed [WID-1:0] exp_q[$];

  logic signed [WID-1:0] pe_val [N_PE];
  logic signed [WID-1:0] tree_pipe [5];
  logic signed [WID-1:0] tree_in_sum;

  always #5 clk = ~clk;

  adder_tree_ctrl #(
    .N_PE   (N_PE),
    .WID    (WID),
    .PASS_W (PASS_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .job_start      (job_start),
    .job_n_pe       (job_n_pe),
    .job_n_pass     (job_n_pass),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .adder_enable   (adder_enable),
    .mac_enable     (mac_enable),
    .adder_tree_out (adder_tree_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy)
  );

  // Tree model: masked input sum, then five enable-gated register stages.
  always_comb begin
    tree_in_sum = '0;
    for (int i = 0; i < N_PE; i++) begin
      if (mac_enable[i]) tree_in_sum = tree_in_sum + pe_val[i];
    end
  end

  always @(posedge clk) begin
    if (adder_enable) begin
      tree_pipe[0] <= tree_in_sum;
      for (int i = 1; i < 5; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
  end

  assign adder_tree_out = tree_pipe[4];

  // Monitor: compare each accepted result against the scoreboard.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected actual=%0d required=none", out_data);
      end else begin
        logic signed [WID-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL result actual=%0d required=%0d", out_data, e);
        end else begin
          $display("result out_data=%0d ok", out_data);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issue one job; returns at the negedge where out_valid is first seen.
  task automatic run_job(input string name, input int n_pe, input int n_pass, input int val,
                         input int gap_t, input logic [31:0] exp_mask, input int exp_sum,
                         input int exp_lat);
    int t;
    bit seen;
    for (int i = 0; i < N_PE; i++) pe_val[i] = val[WID-1:0];
    exp_q.push_back(exp_sum[WID-1:0]);
    @(posedge clk); #1;
    job_start  = 1'b1;
    job_n_pe   = n_pe[5:0];
    job_n_pass = n_pass[PASS_W-1:0];
    in_valid   = 1'b1;
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 300) begin
      @(posedge clk); #1;
      t++;
      job_start = 1'b0;
      in_valid  = (t != gap_t);
      @(negedge clk);
      if (t == 1) check({name, "_mac_enable"}, mac_enable, exp_mask);
      if (t == gap_t) check({name, "_gap_mask"}, mac_enable, 0);
      if (out_valid) seen = 1'b1;
    end
    check({name, "_latency"}, seen ? t : -1, exp_lat);
    $display("job %s n_pe=%0d n_pass=%0d latency=%0d", name, n_pe, n_pass, t);
    in_valid = 1'b0;
  endtask

  // After a handshake, the next cycle must be idle.
  task automatic post_job(input string name);
    @(negedge clk);
    check({name, "_out_valid_drop"}, out_valid, 0);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_in_ready"}, in_ready, 0);
    check({name, "_adder_enable"}, adder_enable, 0);
    check({name, "_mac_enable"}, mac_enable, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_data"}, out_data, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    int sat_exp;
    rst        = 1'b0;
    job_start  = 1'b0;
    job_n_pe   = '0;
    job_n_pass = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < N_PE; i++) pe_val[i] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Single pass over all 32 PEs.
    run_job("t1_full", 32, 1, 1, 0, 32'hFFFF_FFFF, 32, 7);
    post_job("t1_full");

    // Four PEs, three passes, one in_valid gap.
    run_job("t2_gap", 4, 3, 2, 2, 32'h0000_000F, 24, 10);
    post_job("t2_gap");

    // Zero counts mean one pass over every PE.
    run_job("t3_zero", 0, 0, -1, 0, 32'hFFFF_FFFF, -32, 7);
    post_job("t3_zero");

    // Output back-pressure with an ignored job_start.
    out_ready = 1'b0;
    run_job("t4_hold", 5, 1, 1, 0, 32'h0000_001F, 5, 7);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      job_start  = (k == 3);
      job_n_pass = 8'd9;
      @(negedge clk);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", out_data, 5);
      check("t4_hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    job_start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    post_job("t4_hold");

    // Four passes of 16000 overflow the 16-bit output.
`ifdef ACC_SAT_EN
    sat_exp = 32767;
`else
    sat_exp = -1536;
`endif
    run_job("t5_sat", 32, 4, 500, 0, 32'hFFFF_FFFF, sat_exp, 10);
    post_job("t5_sat");

    // Reset in DRAIN with two beats still in the tree.
    for (int i = 0; i < N_PE; i++) pe_val[i] = 16'sd7;
    @(posedge clk); #1;
    job_start  = 1'b1;
    job_n_pe   = 6'd32;
    job_n_pass = 8'd3;
    in_valid   = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      @(posedge clk); #1;
      job_start = 1'b0;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_abort");
    @(negedge clk);
    rst = 1'b1;
    run_job("t6_after", 2, 2, 3, 0, 32'h0000_0003, 12, 8);
    post_job("t6_after");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
